scalu_arb: RTL and testbench
============================

Name: scalu_arb

Overview:
- Arbitrates between NREQ issue sources (e.g. integer and branch/extension reservation-station ports) for the single shared scalu.
- Round-robin grant into one registered issue slot that drives the scalu exers-side interface; the slot holds while scalu_stall is asserted.
- Honours rob_flush; guarantees starvation-free access for every requester.

Parameters:
NREQ, 2, number of requesters (2..8)
PTRW, $clog2(NREQ) (min 1), width of round-robin pointer

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
req_valid  in  NREQ  requester i has a valid op
req_op  in  5*NREQ  scalu op, requester i at [5i+4:5i]
req_robid  in  7*NREQ  ROB id, [7i+6:7i]
req_rd  in  6*NREQ  dest reg, [6i+5:6i]
req_op1  in  32*NREQ  operand 1, [32i+31:32i]
req_op2  in  32*NREQ  operand 2, [32i+31:32i]
req_ready  out  NREQ  one-hot/zero; requester i's op is taken this cycle
exers_scalu_issue  out  1  issue slot valid toward scalu
exers_scalu_op  out  5  slot op
exers_robid  out  7  slot ROB id
exers_rd  out  6  slot dest
exers_op1  out  32  slot operand 1
exers_op2  out  32  slot operand 2
scalu_stall  in  1  scalu cannot accept; slot must hold
rob_flush  in  1  pipeline flush

Behaviour:
- Reset (rst=0, async): slot valid=0, all slot fields=0, pointer=0; req_ready=0 combinationally while rst=0.
- Slot consumed in cycle c iff slot valid & ~scalu_stall. load_en = ~rob_flush & (~slot valid | ~scalu_stall).
- Grant: search req_valid from index ptr upward, wrapping at NREQ; first valid index g wins. At most one req_ready bit; req_ready[g] = load_en & req_valid[g]. req_ready never depends on a requester's own req_ready (no combinational loop beyond req_valid).
- Transfer: on rising edge with load_en: slot <= requester g fields, slot valid <= |req_valid. If load_en & no req_valid: slot valid <= 0, fields unchanged.
- Pointer: on any grant, ptr <= (g+1) mod NREQ; otherwise unchanged. Every requester waits at most NREQ-1 grants.
- Hold: slot valid & scalu_stall & ~rob_flush: slot and pointer unchanged; req_ready=0.
- Flush: rob_flush=1 on an edge: slot valid <= 0, no grant (req_ready=0 that cycle), pointer unchanged. Flush dominates stall.
- Latency: a request presented with an empty slot appears on exers_* the next cycle (1-cycle arbitration register); back-to-back issue at 1 op/cycle when scalu_stall=0.
- Requester contract: req_valid/fields held stable until req_ready; arbiter need not tolerate withdrawal, but must not grant a deasserted request.
- Data passes unmodified; no width conversion.
- Reset asserted mid-stall/mid-flush: slot cleared immediately; after rst deasserts, first grant starts at index 0.

Test Plan:
- Reset then req_valid=01, op=5'h00, robid=7'h05, op1=3, op2=4 -> req_ready=01 same cycle; next cycle exers_scalu_issue=1, op=0, robid=5, op1=3, op2=4.
- Both requesters valid continuously, scalu_stall=0 -> grants alternate 0,1,0,1; exers_robid alternates between the two ROB ids every cycle.
- Slot valid, scalu_stall=1 for 3 cycles with both requesting -> req_ready=00, exers_* unchanged; on stall drop next requester in rotation granted.
- rob_flush=1 with slot valid and req_valid=11 -> next cycle exers_scalu_issue=0, req_ready=00 during flush cycle, pointer unchanged (same winner after flush).
- NREQ=4, only req 3 then only req 0 valid -> ptr wraps 3->0; req 0 granted on next cycle.
- rst driven low asynchronously mid-stall -> exers_scalu_issue=0 before next edge; after release, with req_valid=1111, requester 0 granted first.

Source files
------------

// File: rtl/scalu_arb.sv
// Round-robin arbiter feeding one registered issue slot into the shared scalu; 1-cycle request-to-issue latency.
// Backpressure: slot holds and grants stop while scalu_stall; rob_flush empties the slot and blocks grants.
module scalu_arb #(
    parameter int NREQ = 2,
    parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_op,
    input  logic [7*NREQ-1:0]    req_robid,
    input  logic [6*NREQ-1:0]    req_rd,
    input  logic [32*NREQ-1:0]   req_op1,
    input  logic [32*NREQ-1:0]   req_op2,
    output logic [NREQ-1:0]      req_ready,
    output logic                 exers_scalu_issue,
    output logic [4:0]           exers_scalu_op,
    output logic [6:0]           exers_robid,
    output logic [5:0]           exers_rd,
    output logic [31:0]          exers_op1,
    output logic [31:0]          exers_op2,
    input  logic                 scalu_stall,
    input  logic                 rob_flush
);

    logic             r_vld;
    logic [4:0]       r_op;
    logic [6:0]       r_robid;
    logic [5:0]       r_rd;
    logic [31:0]      r_op1;
    logic [31:0]      r_op2;
    logic [PTRW-1:0]  r_ptr;

    logic             w_load_en;
    logic             w_found;
    logic [PTRW-1:0]  w_gnt_idx;
    logic [PTRW-1:0]  w_ptr_nxt;

    assign w_load_en = ~rob_flush & (~r_vld | ~scalu_stall);

    // Scan from the pointer upward with wrap; first valid requester wins.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_found   = 1'b1;
                w_gnt_idx = PTRW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_ptr_nxt = (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + PTRW'(1);

    always_comb begin
        req_ready = '0;
        if (rst && w_load_en && w_found) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld   <= 1'b0;
            r_op    <= '0;
            r_robid <= '0;
            r_rd    <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_ptr   <= '0;
        end else if (rob_flush) begin
            r_vld <= 1'b0;
        end else if (w_load_en) begin
            r_vld <= w_found;
            if (w_found) begin
                r_op    <= req_op   [int'(w_gnt_idx)*5  +: 5];
                r_robid <= req_robid[int'(w_gnt_idx)*7  +: 7];
                r_rd    <= req_rd   [int'(w_gnt_idx)*6  +: 6];
                r_op1   <= req_op1  [int'(w_gnt_idx)*32 +: 32];
                r_op2   <= req_op2  [int'(w_gnt_idx)*32 +: 32];
                r_ptr   <= w_ptr_nxt;
            end
        end
    end

    assign exers_scalu_issue = r_vld;
    assign exers_scalu_op    = r_op;
    assign exers_robid       = r_robid;
    assign exers_rd          = r_rd;
    assign exers_op1         = r_op1;
    assign exers_op2         = r_op2;

endmodule

// File: tb/tb_scalu_arb.sv
// Bench for scalu_arb (NREQ=4): directed vectors with literal expectations plus a per-cycle model comparison.
module tb_scalu_arb;
    localparam int NREQ = 4;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [5*NREQ-1:0]  req_op;
    logic [7*NREQ-1:0]  req_robid;
    logic [6*NREQ-1:0]  req_rd;
    logic [32*NREQ-1:0] req_op1;
    logic [32*NREQ-1:0] req_op2;
    logic [NREQ-1:0]    req_ready;
    logic               exers_scalu_issue;
    logic [4:0]         exers_scalu_op;
    logic [6:0]         exers_robid;
    logic [5:0]         exers_rd;
    logic [31:0]        exers_op1;
    logic [31:0]        exers_op2;
    logic               scalu_stall;
    logic               rob_flush;

    int checks = 0;
    int errors = 0;

    scalu_arb #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_robid(req_robid), .req_rd(req_rd),
        .req_op1(req_op1), .req_op2(req_op2), .req_ready(req_ready),
        .exers_scalu_issue(exers_scalu_issue), .exers_scalu_op(exers_scalu_op),
        .exers_robid(exers_robid), .exers_rd(exers_rd),
        .exers_op1(exers_op1), .exers_op2(exers_op2),
        .scalu_stall(scalu_stall), .rob_flush(rob_flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: issue slot contents and the requester that has priority next.
    logic        m_vld;
    logic [4:0]  m_op;
    logic [6:0]  m_robid;
    logic [5:0]  m_rd;
    logic [31:0] m_op1, m_op2;
    int          m_ptr;

    // Winner = valid requester with the smallest circular distance from the priority index.
    function automatic int winner(input logic [NREQ-1:0] v, input int p);
        int best  = -1;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            int d = (i - p + NREQ) % NREQ;
            if (v[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int w = winner(req_valid, m_ptr);
        logic [NREQ-1:0] r = '0;
        if (rst && !rob_flush && (!m_vld || !scalu_stall) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_vld <= 1'b0; m_op <= '0; m_robid <= '0; m_rd <= '0;
            m_op1 <= '0; m_op2 <= '0; m_ptr <= 0;
        end else if (rob_flush) begin
            m_vld <= 1'b0;
        end else if (!m_vld || !scalu_stall) begin
            int w;
            w = winner(req_valid, m_ptr);
            if (w < 0) begin
                m_vld <= 1'b0;
            end else begin
                m_vld   <= 1'b1;
                m_op    <= req_op[w*5 +: 5];
                m_robid <= req_robid[w*7 +: 7];
                m_rd    <= req_rd[w*6 +: 6];
                m_op1   <= req_op1[w*32 +: 32];
                m_op2   <= req_op2[w*32 +: 32];
                m_ptr   <= (w + 1) % NREQ;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("mdl_ready", 64'(req_ready), 64'(exp_ready()));
        chk("mdl_issue", 64'(exers_scalu_issue), 64'(m_vld));
        chk("mdl_op", 64'(exers_scalu_op), 64'(m_op));
        chk("mdl_robid", 64'(exers_robid), 64'(m_robid));
        chk("mdl_rd", 64'(exers_rd), 64'(m_rd));
        chk("mdl_op1", 64'(exers_op1), 64'(m_op1));
        chk("mdl_op2", 64'(exers_op2), 64'(m_op2));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] op, input logic [6:0] id,
                           input logic [5:0] rd, input logic [31:0] a, input logic [31:0] b);
        req_op[i*5 +: 5]     = op;
        req_robid[i*7 +: 7]  = id;
        req_rd[i*6 +: 6]     = rd;
        req_op1[i*32 +: 32]  = a;
        req_op2[i*32 +: 32]  = b;
    endtask

    initial begin
        rst = 1'b0; req_valid = '0; req_op = '0; req_robid = '0; req_rd = '0;
        req_op1 = '0; req_op2 = '0; scalu_stall = 1'b0; rob_flush = 1'b0;
        tick(); #1;
        chk("rst_issue", 64'(exers_scalu_issue), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Single request, empty slot: granted same cycle, issued next cycle.
        set_req(0, 5'h00, 7'h05, 6'd1, 32'd3, 32'd4);
        req_valid = 4'b0001; #1;
        chk("t1_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'b0000; #1;
        chk("t1_issue", 64'(exers_scalu_issue), 64'd1);
        chk("t1_op", 64'(exers_scalu_op), 64'd0);
        chk("t1_robid", 64'(exers_robid), 64'd5);
        chk("t1_op1", 64'(exers_op1), 64'd3);
        chk("t1_op2", 64'(exers_op2), 64'd4);

        // Two continuous requesters alternate (priority now at 1).
        set_req(0, 5'h02, 7'd10, 6'd2, 32'hA, 32'hB);
        set_req(1, 5'h03, 7'd20, 6'd3, 32'hC, 32'hD);
        req_valid = 4'b0011; #1;
        chk("t2_ready0", 64'(req_ready), 64'h2);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("t2_robid", 64'(exers_robid), (k % 2 == 0) ? 64'd20 : 64'd10);
        end

        // Stall holds the slot and blocks grants; requester 1 wins on release.
        scalu_stall = 1'b1; #1;
        for (int k = 0; k < 3; k++) begin
            chk("t3_ready", 64'(req_ready), 64'h0);
            tick(); #1;
            chk("t3_robid", 64'(exers_robid), 64'd10);
        end
        scalu_stall = 1'b0; #1;
        chk("t3_release", 64'(req_ready), 64'h2);
        tick(); #1;
        chk("t3_robid1", 64'(exers_robid), 64'd20);

        // Flush empties the slot, grants nothing, and keeps the rotation.
        rob_flush = 1'b1; #1;
        chk("t4_ready", 64'(req_ready), 64'h0);
        tick();
        rob_flush = 1'b0; #1;
        chk("t4_issue", 64'(exers_scalu_issue), 64'd0);
        chk("t4_ready_after", 64'(req_ready), 64'h1);
        tick(); #1;
        chk("t4_robid", 64'(exers_robid), 64'd10);

        // Pointer wrap: requester 3 then requester 0.
        set_req(3, 5'h07, 7'd33, 6'd7, 32'h33, 32'h34);
        req_valid = 4'b1000; #1;
        chk("t5_ready3", 64'(req_ready), 64'h8);
        tick();
        set_req(0, 5'h01, 7'd40, 6'd4, 32'h40, 32'h41);
        req_valid = 4'b0001; #1;
        chk("t5_ready0", 64'(req_ready), 64'h1);
        tick(); #1;
        chk("t5_robid", 64'(exers_robid), 64'd40);

        // Async reset during a stall, then priority restarts at requester 0.
        set_req(1, 5'h05, 7'd21, 6'd5, 32'h21, 32'h22);
        set_req(2, 5'h06, 7'd22, 6'd6, 32'h23, 32'h24);
        req_valid = 4'b1111;
        scalu_stall = 1'b1;
        tick(); #1;
        chk("t6_hold", 64'(exers_robid), 64'd40);
        rst = 1'b0; #1;
        chk("t6_rst_issue", 64'(exers_scalu_issue), 64'd0);
        chk("t6_rst_ready", 64'(req_ready), 64'h0);
        tick();
        rst = 1'b1;
        scalu_stall = 1'b0; #1;
        chk("t6_first", 64'(req_ready), 64'h1);
        tick(); #1;
        chk("t6_robid0", 64'(exers_robid), 64'd40);
        tick(); #1;
        chk("t6_robid1", 64'(exers_robid), 64'd21);
        req_valid = '0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
